// File: rtl/dda_fsm.sv
// rtl/dda_fsm.sv - Raycaster DDA stepping engine: walks the map grid per ray until a wall or the step cap.
module dda_fsm #(
    parameter int NUM_COLS  = 320,
    parameter int MAP_W     = 5,
    parameter int MAP_LAT   = 2,
    parameter int MAX_STEPS = 64
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic               dda_fifo_tvalid_in,
    input  logic [94:0]        dda_fifo_tdata_in,
    output logic               dda_fsm_tready_out,
    output logic [2*MAP_W-1:0] map_addr_out,
    input  logic [3:0]         map_data_in,
    output logic               dda_fsm_tvalid_out,
    output logic [38:0]        dda_fsm_tdata_out,
    output logic               dda_fsm_tlast_out,
    input  logic               dda_fsm_tready_in
);

    localparam int FW = $clog2(MAP_LAT + 1);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [MAP_W-1:0] MAP_ONE   = 1;
    localparam logic [FW-1:0]    FETCH_ONE = 1;
    localparam logic [FW-1:0]    FETCH_END = FW'(MAP_LAT - 1);
    localparam logic [SW-1:0]    STEP_ONE  = 1;
    localparam logic [SW-1:0]    STEP_MAX  = SW'(MAX_STEPS);
    localparam logic [8:0]       LAST_COL  = 9'(NUM_COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_FETCH, S_CHECK, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [8:0]         col_q, col_d;
    logic               step_x_neg_q, step_x_neg_d, step_y_neg_q, step_y_neg_d;
    logic [MAP_W-1:0]   map_x_q, map_x_d, map_y_q, map_y_d;
    logic [15:0]        sdx_q, sdx_d, sdy_q, sdy_d, ddx_q, ddx_d, ddy_q, ddy_d;
    logic               side_q, side_d;
    logic [SW-1:0]      step_cnt_q, step_cnt_d;
    logic [FW-1:0]      fetch_cnt_q, fetch_cnt_d;
    logic [2*MAP_W-1:0] addr_q, addr_d;
    logic [38:0]        tdata_q, tdata_d;
    logic               tlast_q, tlast_d, tvalid_q, tvalid_d, tready_q, tready_d;
    logic [15:0]        perp_base, perp_sub, perp;

    // Low ten input bits carry no ray field.
    logic unused_tdata_bits;
    assign unused_tdata_bits = ^dda_fifo_tdata_in[9:0];

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        perp_base = side_q ? sdy_q : sdx_q;
        perp_sub  = side_q ? ddy_q : ddx_q;
        perp      = (perp_base >= perp_sub) ? (perp_base - perp_sub) : 16'h0000;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        step_x_neg_d = step_x_neg_q;
        step_y_neg_d = step_y_neg_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        sdx_d        = sdx_q;
        sdy_d        = sdy_q;
        ddx_d        = ddx_q;
        ddy_d        = ddy_q;
        side_d       = side_q;
        step_cnt_d   = step_cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        addr_d       = addr_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        case (state_q)
            S_IDLE: begin
                if (dda_fifo_tvalid_in && tready_q) begin
                    col_d        = dda_fifo_tdata_in[94:86];
                    step_x_neg_d = dda_fifo_tdata_in[85];
                    step_y_neg_d = dda_fifo_tdata_in[84];
                    map_x_d      = dda_fifo_tdata_in[83:79];
                    map_y_d      = dda_fifo_tdata_in[78:74];
                    sdx_d        = dda_fifo_tdata_in[73:58];
                    sdy_d        = dda_fifo_tdata_in[57:42];
                    ddx_d        = dda_fifo_tdata_in[41:26];
                    ddy_d        = dda_fifo_tdata_in[25:10];
                    step_cnt_d   = '0;
                    state_d      = S_STEP;
                end
            end
            S_STEP: begin
                // A tie steps along Y.
                if (sdx_q < sdy_q) begin
                    sdx_d   = sat_add(sdx_q, ddx_q);
                    map_x_d = step_x_neg_q ? (map_x_q - MAP_ONE) : (map_x_q + MAP_ONE);
                    side_d  = 1'b0;
                end else begin
                    sdy_d   = sat_add(sdy_q, ddy_q);
                    map_y_d = step_y_neg_q ? (map_y_q - MAP_ONE) : (map_y_q + MAP_ONE);
                    side_d  = 1'b1;
                end
                step_cnt_d  = step_cnt_q + STEP_ONE;
                addr_d      = {map_y_d, map_x_d};
                fetch_cnt_d = '0;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_cnt_q == FETCH_END) begin
                    state_d = S_CHECK;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FETCH_ONE;
                end
            end
            S_CHECK: begin
                tlast_d = (col_q == LAST_COL);
                if (map_data_in != 4'd0) begin
                    tdata_d = {col_q, side_q, map_data_in, perp, map_x_q, map_y_q[3:0]};
                    state_d = S_EMIT;
                end else if (step_cnt_q == STEP_MAX) begin
                    tdata_d = {col_q, side_q, 4'd0, 16'hFFFF, map_x_q, map_y_q[3:0]};
                    state_d = S_EMIT;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_EMIT: begin
                if (tvalid_q && dda_fsm_tready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        tvalid_d = (state_d == S_EMIT);
        tready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            step_x_neg_q <= 1'b0;
            step_y_neg_q <= 1'b0;
            map_x_q      <= '0;
            map_y_q      <= '0;
            sdx_q        <= '0;
            sdy_q        <= '0;
            ddx_q        <= '0;
            ddy_q        <= '0;
            side_q       <= 1'b0;
            step_cnt_q   <= '0;
            fetch_cnt_q  <= '0;
            addr_q       <= '0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            tready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            step_x_neg_q <= step_x_neg_d;
            step_y_neg_q <= step_y_neg_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            sdx_q        <= sdx_d;
            sdy_q        <= sdy_d;
            ddx_q        <= ddx_d;
            ddy_q        <= ddy_d;
            side_q       <= side_d;
            step_cnt_q   <= step_cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            addr_q       <= addr_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            tready_q     <= tready_d;
        end
    end

    assign dda_fsm_tready_out = tready_q;
    assign map_addr_out       = addr_q;
    assign dda_fsm_tvalid_out = tvalid_q;
    assign dda_fsm_tdata_out  = tdata_q;
    assign dda_fsm_tlast_out  = tlast_q;

endmodule

// File: tb/tb_dda_fsm.sv
// tb/tb_dda_fsm.sv - Directed self-checking bench for dda_fsm with a 2-cycle map ROM model.
module tb_dda_fsm;

    logic        clk;
    logic        rst_n;
    logic        in_tvalid;
    logic [94:0] in_tdata;
    logic        in_tready;
    logic [9:0]  map_addr;
    logic [3:0]  map_data;
    logic        out_tvalid;
    logic [38:0] out_tdata;
    logic        out_tlast;
    logic        out_tready;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int tlasts = 0;
    int overlap = 0;

    logic [3:0] map_mem [0:1023];
    logic [3:0] rd1, rd2;

    dda_fsm dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst_n),
        .dda_fifo_tvalid_in (in_tvalid),
        .dda_fifo_tdata_in  (in_tdata),
        .dda_fsm_tready_out (in_tready),
        .map_addr_out       (map_addr),
        .map_data_in        (map_data),
        .dda_fsm_tvalid_out (out_tvalid),
        .dda_fsm_tdata_out  (out_tdata),
        .dda_fsm_tlast_out  (out_tlast),
        .dda_fsm_tready_in  (out_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= map_mem[map_addr];
        rd2 <= rd1;
    end
    assign map_data = rd2;

    always @(posedge clk) begin
        if (rst_n && out_tvalid && out_tready) begin
            xfers++;
            if (out_tlast) tlasts++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_tvalid && in_tready) overlap++;
    end

    function automatic logic [94:0] ray(input logic [8:0] col, input logic sxn, input logic syn,
                                        input logic [4:0] mx, input logic [4:0] my,
                                        input logic [15:0] sdx, input logic [15:0] sdy,
                                        input logic [15:0] ddx, input logic [15:0] ddy);
        return {col, sxn, syn, mx, my, sdx, sdy, ddx, ddy, 10'd0};
    endfunction

    task automatic clear_map();
        for (int i = 0; i < 1024; i++) map_mem[i] = 4'd0;
    endtask

    task automatic set_cell(input int x, input int y, input logic [3:0] v);
        map_mem[y*32 + x] = v;
    endtask

    task automatic send_ray(input logic [94:0] v, output bit ok);
        int n;
        @(negedge clk);
        in_tdata  = v;
        in_tvalid = 1'b1;
        n = 0;
        while (!in_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = in_tready;
        @(posedge clk);
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic get_result(output logic [38:0] d, output logic l, output int lat, output bit ok);
        lat = 1;
        while (!out_tvalid && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ok = out_tvalid;
        d  = out_tdata;
        l  = out_tlast;
        if (ok && out_tready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({in_tready, out_tvalid, out_tlast, out_tdata, map_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%h addr=%h, want all 0",
                     in_tready, out_tvalid, out_tlast, out_tdata, map_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_tready);
        end
    endtask

    task automatic test_single_hit();
        logic [38:0] d;
        logic l;
        int lat;
        bit ok_s, ok_r;
        clear_map();
        set_cell(4, 2, 4'd7);
        send_ray(ray(9'd5, 1'b0, 1'b0, 5'd3, 5'd2, 16'h0080, 16'h0200, 16'h0100, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r)) begin
            errors++;
            $display("FAIL hit_timeout: accept=%0d result=%0d want 1 1", ok_s, ok_r);
        end
        checks++;
        if (d !== {9'd5, 1'b0, 4'd7, 16'h0080, 5'd4, 4'd2}) begin
            errors++;
            $display("FAIL hit_tdata: got %h want %h", d, {9'd5, 1'b0, 4'd7, 16'h0080, 5'd4, 4'd2});
        end
        checks++;
        if (l !== 1'b0) begin
            errors++;
            $display("FAIL hit_tlast: got %b want 0", l);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL hit_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_tie();
        logic [38:0] d;
        logic l;
        int lat;
        bit ok_s, ok_r;
        clear_map();
        set_cell(4, 2, 4'd7);
        set_cell(3, 3, 4'd9);
        send_ray(ray(9'd10, 1'b0, 1'b0, 5'd3, 5'd2, 16'h0100, 16'h0100, 16'h0100, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r) || d !== {9'd10, 1'b1, 4'd9, 16'h0100, 5'd3, 4'd3}) begin
            errors++;
            $display("FAIL tie_tdata: got %h want %h", d, {9'd10, 1'b1, 4'd9, 16'h0100, 5'd3, 4'd3});
        end
    endtask

    task automatic test_neg_wrap();
        logic [38:0] d;
        logic l;
        int lat;
        bit ok_s, ok_r;
        clear_map();
        set_cell(31, 0, 4'd3);
        send_ray(ray(9'd6, 1'b1, 1'b0, 5'd0, 5'd0, 16'h0010, 16'h0100, 16'h0100, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r) || d !== {9'd6, 1'b0, 4'd3, 16'h0010, 5'd31, 4'd0}) begin
            errors++;
            $display("FAIL wrap_tdata: got %h want %h", d, {9'd6, 1'b0, 4'd3, 16'h0010, 5'd31, 4'd0});
        end
    endtask

    task automatic test_miss();
        logic [38:0] d;
        logic l;
        int lat;
        bit ok_s, ok_r;
        clear_map();
        send_ray(ray(9'd20, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0100, 16'h0200, 16'h0100, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r) || d[38:30] !== 9'd20 || d[28:25] !== 4'd0 || d[24:9] !== 16'hFFFF) begin
            errors++;
            $display("FAIL miss_fields: got col=%0d wall=%0d perp=%h want 20 0 ffff", d[38:30], d[28:25], d[24:9]);
        end
        checks++;
        if (lat != 257) begin
            errors++;
            $display("FAIL miss_latency: got %0d want 257", lat);
        end
    endtask

    task automatic test_saturate();
        logic [38:0] d;
        logic l;
        int lat;
        bit ok_s, ok_r;
        clear_map();
        set_cell(4, 2, 4'd5);
        send_ray(ray(9'd30, 1'b0, 1'b0, 5'd3, 5'd2, 16'h8000, 16'hFFFF, 16'hFF00, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r) || d !== {9'd30, 1'b0, 4'd5, 16'h00FF, 5'd4, 4'd2}) begin
            errors++;
            $display("FAIL saturate_tdata: got %h want %h", d, {9'd30, 1'b0, 4'd5, 16'h00FF, 5'd4, 4'd2});
        end
    endtask

    task automatic test_stall_last();
        logic [38:0] d;
        logic l;
        int lat, bad, x0;
        bit ok_s, ok_r;
        clear_map();
        set_cell(4, 2, 4'd7);
        out_tready = 1'b0;
        x0 = xfers;
        send_ray(ray(9'd319, 1'b0, 1'b0, 5'd3, 5'd2, 16'h0080, 16'h0200, 16'h0100, 16'h0100), ok_s);
        get_result(d, l, lat, ok_r);
        checks++;
        if (!(ok_s && ok_r) || d !== {9'd319, 1'b0, 4'd7, 16'h0080, 5'd4, 4'd2} || l !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: got %h last=%b want %h last=1", d, l, {9'd319, 1'b0, 4'd7, 16'h0080, 5'd4, 4'd2});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_tvalid !== 1'b1 || out_tdata !== d || out_tlast !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
        end
        out_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b want 0 1", out_tvalid, in_tready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (xfers - x0 != 1) begin
            errors++;
            $display("FAIL stall_xfers: got %0d want 1", xfers - x0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok_s;
        int seen;
        clear_map();
        set_cell(4, 2, 4'd7);
        send_ray(ray(9'd7, 1'b0, 1'b0, 5'd3, 5'd2, 16'h0080, 16'h0200, 16'h0100, 16'h0100), ok_s);
        @(posedge clk);
        #2;
        checks++;
        if (!ok_s || map_addr !== 10'h044) begin
            errors++;
            $display("FAIL fetch_addr: got %h want 044", map_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_tready, out_tvalid, out_tlast, out_tdata, map_addr} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b addr=%h data=%h, want all 0",
                     in_tready, out_tvalid, map_addr, out_tdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", in_tready);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_tvalid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_stale: %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [38:0] d;
        logic l;
        int lat, bad, x0, t0;
        bit ok_s, ok_r;
        clear_map();
        set_cell(4, 2, 4'd7);
        out_tready = 1'b1;
        x0 = xfers;
        t0 = tlasts;
        bad = 0;
        for (int c = 0; c < 320; c++) begin
            send_ray(ray(9'(c), 1'b0, 1'b0, 5'd3, 5'd2, 16'h0080, 16'h0200, 16'h0100, 16'h0100), ok_s);
            get_result(d, l, lat, ok_r);
            if (!(ok_s && ok_r) || d[38:30] !== 9'(c) || l !== (c == 319)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_results: %0d bad rays, want 0", bad);
        end
        checks++;
        if (xfers - x0 != 320 || tlasts - t0 != 1) begin
            errors++;
            $display("FAIL b2b_counts: xfers=%0d tlast=%0d want 320 1", xfers - x0, tlasts - t0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        clear_map();
        test_reset();
        test_single_hit();
        test_tie();
        test_neg_wrap();
        test_miss();
        test_saturate();
        test_stall_last();
        test_reset_mid_fetch();
        test_back_to_back();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL ready_valid_overlap: got %0d cycles want 0", overlap);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
